// File: rtl/fwd_scoreboard_pkg.sv
// Shared bus definitions for the operand-forwarding scoreboard: default widths,
// bus-slice geometry and the position of the per-slot pend/llbit flags.
package fwd_scoreboard_pkg;
  localparam int FWD_AW       = 5;
  localparam int FWD_DW       = 32;
  localparam int FWD_LANES    = 2;
  localparam int FWD_STAGES   = 2;
  localparam int SRC_PER_LANE = 2;

  // Per producer slot flag word
  localparam int FLAG_PEND = 0;
  localparam int FLAG_LL   = 1;
  localparam int FLAG_W    = 2;

  typedef struct packed {
    logic hit;
    logic pend;
  } fwd_win_t;

  // Producer slot index: stage-major, lane-minor
  function automatic int fwd_slot(int stage, int lane, int lanes);
    return stage * lanes + lane;
  endfunction

  function automatic int src_slot(int lane, int j);
    return lane * SRC_PER_LANE + j;
  endfunction
endpackage

// File: rtl/sb_counter.sv
// One register's outstanding long-latency write count: 2-bit saturating
// up/down counter with synchronous flush.
module sb_counter #(
  parameter int NW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [NW-1:0] inc,
  input  logic [NW-1:0] dec,
  output logic [1:0]    cnt
);
  logic [NW+1:0] up;
  logic [1:0]    nxt;

  always_comb begin
    up  = (NW+2)'(cnt) + (NW+2)'(inc);
    nxt = cnt;
    if (up < (NW+2)'(dec))                         nxt = 2'd0;
    else if (up - (NW+2)'(dec) > (NW+2)'(3))      nxt = 2'd3;
    else                                           nxt = 2'(up - (NW+2)'(dec));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     cnt <= 2'd0;
    else if (flush) cnt <= 2'd0;
    else            cnt <= nxt;
  end

  // Issue side must stall on sb_full; retire must never outnumber issues
  a_no_wrap: assert property (@(posedge clk) disable iff (!rst_n || flush)
    (up >= (NW+2)'(dec)) && (up - (NW+2)'(dec) <= (NW+2)'(3)));
endmodule

// File: rtl/fwd_scoreboard.sv
// Decode-stage operand forwarding mux, llbit forwarding, intra-bundle hazard
// detection and per-register long-latency scoreboard.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int LANES  = FWD_LANES,
  parameter int STAGES = FWD_STAGES,
  parameter int AW     = FWD_AW,
  parameter int DW     = FWD_DW
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      flush,
  input  logic [STAGES*LANES-1:0]                   fwd_we,
  input  logic [STAGES*LANES-1:0][AW-1:0]           fwd_waddr,
  input  logic [STAGES*LANES-1:0][DW-1:0]           fwd_wdata,
  input  logic [STAGES*LANES-1:0]                   fwd_pend,
  input  logic [STAGES*LANES-1:0]                   fwd_llwe,
  input  logic [STAGES*LANES-1:0]                   fwd_llwdata,
  input  logic [LANES*SRC_PER_LANE-1:0]             rd_re,
  input  logic [LANES*SRC_PER_LANE-1:0][AW-1:0]     rd_raddr,
  input  logic [LANES*SRC_PER_LANE-1:0][DW-1:0]     rd_rdata_i,
  input  logic                                      llbit_i,
  output logic [LANES*SRC_PER_LANE-1:0][DW-1:0]     rd_rdata_o,
  output logic                                      llbit_o,
  output logic [LANES-1:0]                          lane_ready,
  input  logic [LANES-1:0]                          iss_fire,
  input  logic [LANES-1:0]                          iss_we,
  input  logic [LANES-1:0][AW-1:0]                  iss_waddr,
  input  logic [LANES-1:0]                          iss_long,
  input  logic [LANES-1:0]                          wb_clr,
  input  logic [LANES-1:0][AW-1:0]                  wb_waddr,
  output logic                                      sb_full,
  output logic [31:0]                               stall_cnt
);
  localparam int NSLOT = STAGES * LANES;
  localparam int NSRC  = LANES * SRC_PER_LANE;
  localparam int NREG  = 1 << AW;
  localparam int NW    = $clog2(LANES + 1);

  logic [NREG-1:0][1:0]        cnt;
  logic [NSLOT-1:0][FLAG_W-1:0] flags;
  logic [NSRC-1:0]             src_ok;
  logic [LANES-1:0]            lane_ok;
  logic [31:0]                 stall_q;

  always_comb begin
    flags = '0;
    for (int i = 0; i < NSLOT; i++) begin
      flags[i][FLAG_PEND] = fwd_pend[i];
      flags[i][FLAG_LL]   = fwd_llwe[i];
    end
  end

  // Walk lowest priority first so the last hit is the winner
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_win_t        win;
    logic [DW-1:0]   data;
    always_comb begin
      win  = '0;
      data = rd_rdata_i[i];
      for (int s = STAGES - 1; s >= 0; s--)
        for (int l = 0; l < LANES; l++)
          if (rd_re[i] && rd_raddr[i] != '0 && fwd_we[fwd_slot(s, l, LANES)] &&
              fwd_waddr[fwd_slot(s, l, LANES)] == rd_raddr[i]) begin
            win.hit  = 1'b1;
            win.pend = flags[fwd_slot(s, l, LANES)][FLAG_PEND];
            data     = fwd_wdata[fwd_slot(s, l, LANES)];
          end
    end
    assign rd_rdata_o[i] = data;
    assign src_ok[i] = win.hit ? !win.pend
                               : !(rd_re[i] && rd_raddr[i] != '0 && cnt[rd_raddr[i]] != 2'd0);
  end

  always_comb begin
    lane_ok    = '0;
    lane_ready = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_ok[l] = src_ok[src_slot(l, 0)] && src_ok[src_slot(l, 1)];
      for (int k = 0; k < l; k++)
        for (int j = 0; j < SRC_PER_LANE; j++)
          if (iss_we[k] && iss_waddr[k] != '0 && rd_re[src_slot(l, j)] &&
              rd_raddr[src_slot(l, j)] == iss_waddr[k])
            lane_ok[l] = 1'b0;
    end
    lane_ready[0] = lane_ok[0];
    for (int l = 1; l < LANES; l++) lane_ready[l] = lane_ok[l] && lane_ready[l-1];
  end

  always_comb begin
    llbit_o = llbit_i;
    for (int s = STAGES - 1; s >= 0; s--)
      for (int l = 0; l < LANES; l++)
        if (flags[fwd_slot(s, l, LANES)][FLAG_LL]) llbit_o = fwd_llwdata[fwd_slot(s, l, LANES)];
  end

  always_comb begin
    sb_full = 1'b0;
    for (int l = 0; l < LANES; l++)
      if (iss_fire[l] && iss_we[l] && iss_long[l] && iss_waddr[l] != '0 &&
          cnt[iss_waddr[l]] == 2'd3)
        sb_full = 1'b1;
  end

  assign cnt[0] = 2'd0;
  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic [NW-1:0] inc, dec;
    always_comb begin
      inc = '0;
      dec = '0;
      for (int l = 0; l < LANES; l++) begin
        if (iss_fire[l] && iss_we[l] && iss_long[l] && iss_waddr[l] == AW'(r)) inc = inc + 1'b1;
        if (wb_clr[l] && wb_waddr[l] == AW'(r)) dec = dec + 1'b1;
      end
    end
    sb_counter #(.NW(NW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .inc   (inc),
      .dec   (dec),
      .cnt   (cnt[r])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                          stall_q <= '0;
    else if (!lane_ready[0] && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: forwarding vector table checked
// through an expectation queue, plus scoreboard/stall sequences.
module tb_fwd_scoreboard;
  logic             clk = 1'b0;
  logic             rst_n, flush;
  logic [3:0]       fwd_we, fwd_pend, fwd_llwe, fwd_llwdata;
  logic [3:0][4:0]  fwd_waddr;
  logic [3:0][31:0] fwd_wdata;
  logic [3:0]       rd_re;
  logic [3:0][4:0]  rd_raddr;
  logic [3:0][31:0] rd_rdata_i, rd_rdata_o;
  logic             llbit_i, llbit_o;
  logic [1:0]       lane_ready, iss_fire, iss_we, iss_long, wb_clr;
  logic [1:0][4:0]  iss_waddr, wb_waddr;
  logic             sb_full;
  logic [31:0]      stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Register file model: r0 reads 0, others read 0xA000_00nn
  always_comb
    for (int i = 0; i < 4; i++)
      rd_rdata_i[i] = (rd_raddr[i] == 5'd0) ? 32'd0 : (32'hA000_0000 | 32'(rd_raddr[i]));

  fwd_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pend(fwd_pend),
    .fwd_llwe(fwd_llwe), .fwd_llwdata(fwd_llwdata),
    .rd_re(rd_re), .rd_raddr(rd_raddr), .rd_rdata_i(rd_rdata_i), .llbit_i(llbit_i),
    .rd_rdata_o(rd_rdata_o), .llbit_o(llbit_o), .lane_ready(lane_ready),
    .iss_fire(iss_fire), .iss_we(iss_we), .iss_waddr(iss_waddr), .iss_long(iss_long),
    .wb_clr(wb_clr), .wb_waddr(wb_waddr), .sb_full(sb_full), .stall_cnt(stall_cnt)
  );

  typedef struct {
    string            nm;
    logic [3:0]       we, pend, llwe, llwd, re;
    logic [3:0][4:0]  wa, ra;
    logic [3:0][31:0] wd;
    logic             ll_i;
    logic [1:0]       iwe;
    logic [1:0][4:0]  iwa;
    int               src;
    logic [31:0]      e_data;
    logic [1:0]       e_rdy;
    logic             e_ll;
  } vec_t;

  typedef struct {
    string       nm;
    int          src;
    logic [31:0] d;
    logic [1:0]  r;
    logic        ll;
  } exp_t;

  vec_t v[12];
  exp_t q[$];
  exp_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; fwd_we = '0; fwd_pend = '0; fwd_llwe = '0; fwd_llwdata = '0;
    fwd_waddr = '0; fwd_wdata = '0; rd_re = '0; rd_raddr = '0; llbit_i = 0;
    iss_fire = '0; iss_we = '0; iss_long = '0; iss_waddr = '0; wb_clr = '0; wb_waddr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input int l, input logic [4:0] a);
    iss_fire[l] = 1; iss_we[l] = 1; iss_long[l] = 1; iss_waddr[l] = a;
  endtask

  task automatic stall_on();
    fwd_we[0] = 1; fwd_waddr[0] = 5'd8; fwd_pend[0] = 1; rd_re[0] = 1; rd_raddr[0] = 5'd8;
  endtask

  function automatic vec_t blank(input string nm);
    vec_t b;
    b.nm = nm; b.we = '0; b.pend = '0; b.llwe = '0; b.llwd = '0; b.re = '0;
    b.wa = '0; b.ra = '0; b.wd = '0; b.ll_i = 0; b.iwe = '0; b.iwa = '0;
    b.src = 0; b.e_data = '0; b.e_rdy = 2'b11; b.e_ll = 0;
    return b;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Slots: 0=EX/l0 1=EX/l1 2=MEM/l0 3=MEM/l1; sources: lane*2+j
    v[0] = blank("p032");
    v[0].we = 4'b0110; v[0].wa[1] = 5; v[0].wd[1] = 32'h11; v[0].wa[2] = 5; v[0].wd[2] = 32'h22;
    v[0].re[0] = 1; v[0].ra[0] = 5; v[0].e_data = 32'h11;
    v[1] = blank("p033_pend");
    v[1].we[0] = 1; v[1].pend[0] = 1; v[1].wa[0] = 7; v[1].wd[0] = 32'h77;
    v[1].re[2] = 1; v[1].ra[2] = 7; v[1].src = 2; v[1].e_data = 32'h77; v[1].e_rdy = 2'b01;
    v[2] = blank("p033_mem");
    v[2].we[2] = 1; v[2].wa[2] = 7; v[2].wd[2] = 32'h99;
    v[2].re[2] = 1; v[2].ra[2] = 7; v[2].src = 2; v[2].e_data = 32'h99;
    v[3] = blank("p034_raw");
    v[3].iwe[0] = 1; v[3].iwa[0] = 3; v[3].re[2] = 1; v[3].ra[2] = 3;
    v[3].src = 2; v[3].e_data = 32'hA000_0003; v[3].e_rdy = 2'b01;
    v[4] = blank("p034_r0");
    v[4].iwe[0] = 1; v[4].iwa[0] = 3; v[4].we[0] = 1; v[4].wa[0] = 0; v[4].wd[0] = 32'hDEAD;
    v[4].re[2] = 1; v[4].ra[2] = 0; v[4].src = 2; v[4].e_data = 32'h0;
    v[5] = blank("prio_lane");
    v[5].we = 4'b1011; v[5].wa[0] = 6; v[5].wd[0] = 32'h60; v[5].wa[1] = 6; v[5].wd[1] = 32'h61;
    v[5].wa[3] = 6; v[5].wd[3] = 32'h63; v[5].re[1] = 1; v[5].ra[1] = 6; v[5].src = 1; v[5].e_data = 32'h61;
    v[6] = blank("ll_mem");
    v[6].llwe = 4'b1100; v[6].llwd = 4'b1000; v[6].e_ll = 1;
    v[7] = blank("ll_ex");
    v[7].llwe = 4'b1101; v[7].llwd = 4'b1000; v[7].ll_i = 1; v[7].e_ll = 0;
    v[8] = blank("ll_arch");
    v[8].ll_i = 1; v[8].e_ll = 1;
    v[9] = blank("inorder");
    v[9].we[0] = 1; v[9].pend[0] = 1; v[9].wa[0] = 8; v[9].wd[0] = 32'h88;
    v[9].re[0] = 1; v[9].ra[0] = 8; v[9].e_data = 32'h88; v[9].e_rdy = 2'b00;
    v[10] = blank("low_pend_ign");
    v[10].we = 4'b0101; v[10].wa[0] = 8; v[10].wd[0] = 32'h80; v[10].wa[2] = 8; v[10].wd[2] = 32'h82;
    v[10].pend[2] = 1; v[10].re[0] = 1; v[10].ra[0] = 8; v[10].e_data = 32'h80;
    v[11] = blank("raw_src1");
    v[11].iwe[0] = 1; v[11].iwa[0] = 12; v[11].re[3] = 1; v[11].ra[3] = 12;
    v[11].src = 3; v[11].e_data = 32'hA000_000C; v[11].e_rdy = 2'b01;

    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_cnt9", 32'(dut.cnt[9]), 32'd0);
    chk("rst_ready", 32'(lane_ready), 32'd3);
    chk("rst_sbfull", 32'(sb_full), 32'd0);
    rst_n = 1;

    foreach (v[i]) begin
      @(negedge clk);
      idle();
      fwd_we = v[i].we; fwd_pend = v[i].pend; fwd_waddr = v[i].wa; fwd_wdata = v[i].wd;
      fwd_llwe = v[i].llwe; fwd_llwdata = v[i].llwd; rd_re = v[i].re; rd_raddr = v[i].ra;
      llbit_i = v[i].ll_i; iss_we = v[i].iwe; iss_waddr = v[i].iwa;
      e.nm = v[i].nm; e.src = v[i].src; e.d = v[i].e_data; e.r = v[i].e_rdy; e.ll = v[i].e_ll;
      q.push_back(e);
      #1;
      e = q.pop_front();
      chk({e.nm, "_data"}, rd_rdata_o[e.src], e.d);
      chk({e.nm, "_ready"}, 32'(lane_ready), 32'(e.r));
      chk({e.nm, "_llbit"}, 32'(llbit_o), 32'(e.ll));
    end

    // Long-latency r9 on both lanes, retired one at a time
    @(negedge clk);
    idle(); issue(0, 9); issue(1, 9);
    #1 chk("s1_sbfull0", 32'(sb_full), 32'd0);
    step(); idle();
    chk("s1_cnt2", 32'(dut.cnt[9]), 32'd2);
    rd_re[0] = 1; rd_raddr[0] = 9;
    #1 chk("s1_rdy_cnt2", 32'(lane_ready), 32'd0);
    wb_clr[0] = 1; wb_waddr[0] = 9;
    step(); idle();
    chk("s1_cnt1", 32'(dut.cnt[9]), 32'd1);
    rd_re[0] = 1; rd_raddr[0] = 9;
    #1 chk("s1_rdy_cnt1", 32'(lane_ready), 32'd0);
    wb_clr[1] = 1; wb_waddr[1] = 9;
    step(); idle();
    chk("s1_cnt0", 32'(dut.cnt[9]), 32'd0);
    rd_re[0] = 1; rd_raddr[0] = 9;
    #1 chk("s1_rdy_cnt0", 32'(lane_ready), 32'd3);
    chk("s1_data", rd_rdata_o[0], 32'hA000_0009);

    // Same-cycle issue/retire, saturation flag, flush
    idle(); issue(1, 4);
    step(); idle();
    chk("s2_cnt4_1", 32'(dut.cnt[4]), 32'd1);
    issue(0, 4); issue(1, 9); wb_clr[1] = 1; wb_waddr[1] = 4;
    step(); idle();
    chk("s2_cnt4_hold", 32'(dut.cnt[4]), 32'd1);
    chk("s2_cnt9_1", 32'(dut.cnt[9]), 32'd1);
    issue(0, 9); issue(1, 9);
    step(); idle();
    chk("s2_cnt9_3", 32'(dut.cnt[9]), 32'd3);
    issue(1, 9);
    #1 chk("s2_sbfull1", 32'(sb_full), 32'd1);
    iss_long[1] = 0;
    #1 chk("s2_sbfull_short", 32'(sb_full), 32'd0);
    idle(); flush = 1; issue(0, 4); wb_clr[1] = 1; wb_waddr[1] = 9;
    step(); idle();
    chk("s2_flush_cnt4", 32'(dut.cnt[4]), 32'd0);
    chk("s2_flush_cnt9", 32'(dut.cnt[9]), 32'd0);

    // Stall counter: count, survive flush, reset, saturate
    rst_n = 0;
    step(); rst_n = 1;
    stall_on();
    repeat (5) step();
    chk("s3_stall5", stall_cnt, 32'd5);
    flush = 1;
    step(); flush = 0;
    chk("s3_stall_flush", stall_cnt, 32'd6);
    rst_n = 0; issue(0, 4);
    #1 chk("s3_rdy_in_rst", 32'(lane_ready), 32'd0);
    step();
    chk("s3_stall_rst", stall_cnt, 32'd0);
    chk("s3_cnt4_rst", 32'(dut.cnt[4]), 32'd0);
    rst_n = 1; iss_fire = '0; iss_we = '0; iss_long = '0;
    force dut.stall_q = 32'hFFFF_FFFE;
    #1 release dut.stall_q;
    step();
    chk("s3_stall_max", stall_cnt, 32'hFFFF_FFFF);
    repeat (2) step();
    chk("s3_stall_sat", stall_cnt, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
